lif_update_unit: RTL and testbench

Neuron update stage directly downstream of the accumulator bank. When the controller releases accumulated synaptic currents (ac output enable), this block consumes one current per neuron and reads that neuron's membrane potential and beta. It computes the leaky-integrate-and-fire update, then writes the new potential to the potential memory and the spike bit to the spike memory. One pass covers one layer slice of N_NEURONS neurons.

---
 rtl/lif_update_unit.sv | 159 +++++++++++++++
 tb/tb_lif_update_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_update_unit.sv
// rtl/lif_update_unit.sv - leaky-integrate-and-fire update stage with a 2-cycle read/compute/write pipeline
// Optional macro SATURATE_EN: saturate the updated potential instead of wrapping it.
module lif_update_unit #(
    parameter int N_NEURONS = 64,
    parameter int U_W       = 16,
    parameter int B_W       = 8,
    parameter int THRESH    = 1024,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ac_valid,
    input  logic [U_W-1:0]    ac_data,
    output logic              ac_ready,
    output logic [ADDR_W-1:0] pot_read_addr,
    output logic [ADDR_W-1:0] beta_read_addr,
    input  logic [U_W-1:0]    pot_read_data,
    input  logic [B_W-1:0]    beta_read_data,
    output logic [ADDR_W-1:0] pot_write_addr,
    output logic [U_W-1:0]    pot_write_data,
    output logic              pot_write_we,
    output logic [ADDR_W-1:0] spk_write_addr,
    output logic              spk_write_data,
    output logic              spk_write_we,
    output logic              busy,
    output logic              done
);

    localparam int                  CNT_W    = $clog2(N_NEURONS + 1);
    localparam logic [CNT_W-1:0]    LAST_IDX = CNT_W'(N_NEURONS - 1);
    localparam logic signed [U_W-1:0] THR    = U_W'(THRESH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         idx;
    logic [ADDR_W-1:0]        base;
    logic                     accept;
    logic                     s1_valid;
    logic signed [U_W-1:0]    s1_cur;
    logic                     s2_valid;
    logic signed [U_W-1:0]    s2_u;
    logic signed [U_W-1:0]    s2_cur;
    logic [B_W-1:0]           s2_beta;
    logic [ADDR_W-1:0]        s2_addr;
    logic signed [U_W+B_W:0]  prod;
    logic signed [U_W+1:0]    sum;
    logic signed [U_W-1:0]    u_new;
    logic signed [U_W-1:0]    pot_next;
    logic                     spk;

    assign accept         = ac_valid && (state == RUN);
    assign beta_read_addr = pot_read_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ac_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = RUN;
            end
            RUN: begin
                ac_ready = 1'b1;
                if (ac_valid && idx == LAST_IDX) state_next = DRAIN;
            end
            // the write register is in its we cycle once stages 1 and 2 are empty
            DRAIN: if (!s1_valid && !s2_valid) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod = $signed({{(B_W+1){s2_u[U_W-1]}}, s2_u}) * $signed({{U_W{1'b0}}, 1'b0, s2_beta});
        sum  = (U_W+2)'(prod >>> B_W) + $signed({{2{s2_cur[U_W-1]}}, s2_cur});
`ifdef SATURATE_EN
        if (sum[U_W+1:U_W-1] == 3'b000 || sum[U_W+1:U_W-1] == 3'b111)
            u_new = sum[U_W-1:0];
        else if (sum[U_W+1])
            u_new = {1'b1, {(U_W-1){1'b0}}};
        else
            u_new = {1'b0, {(U_W-1){1'b1}}};
`else
        u_new = sum[U_W-1:0];
`endif
        spk      = (u_new >= THR);
        pot_next = spk ? u_new - THR : u_new;
    end

`ifndef SATURATE_EN
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[U_W+1:U_W];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx            <= '0;
            base           <= '0;
            s1_valid       <= 1'b0;
            s1_cur         <= '0;
            pot_read_addr  <= '0;
            s2_valid       <= 1'b0;
            s2_u           <= '0;
            s2_cur         <= '0;
            s2_beta        <= '0;
            s2_addr        <= '0;
            pot_write_we   <= 1'b0;
            spk_write_we   <= 1'b0;
            pot_write_addr <= '0;
            spk_write_addr <= '0;
            pot_write_data <= '0;
            spk_write_data <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                base <= base_addr;
                idx  <= '0;
            end else if (accept) begin
                idx <= idx + CNT_W'(1);
            end

            s1_valid <= accept;
            if (accept) begin
                pot_read_addr <= base + ADDR_W'(idx);
                s1_cur        <= ac_data;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_u    <= pot_read_data;
                s2_beta <= beta_read_data;
                s2_cur  <= s1_cur;
                s2_addr <= pot_read_addr;
            end

            pot_write_we <= s2_valid;
            spk_write_we <= s2_valid;
            if (s2_valid) begin
                pot_write_addr <= s2_addr;
                spk_write_addr <= s2_addr;
                pot_write_data <= pot_next;
                spk_write_data <= spk;
            end
        end
    end

endmodule

// File: tb/tb_lif_update_unit.sv
// tb/tb_lif_update_unit.sv - directed table-driven bench for lif_update_unit (N_NEURONS=64)
module tb_lif_update_unit;

    localparam int N = 64;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [8:0]         base_addr = '0;
    logic               ac_valid = 1'b0;
    logic signed [15:0] ac_data = '0;
    logic               ac_ready;
    logic [8:0]         pot_read_addr, beta_read_addr, pot_write_addr, spk_write_addr;
    logic signed [15:0] pot_read_data, pot_write_data;
    logic [7:0]         beta_read_data;
    logic               pot_write_we, spk_write_data, spk_write_we, busy, done;

    lif_update_unit dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .ac_valid(ac_valid), .ac_data(ac_data), .ac_ready(ac_ready),
        .pot_read_addr(pot_read_addr), .beta_read_addr(beta_read_addr),
        .pot_read_data(pot_read_data), .beta_read_data(beta_read_data),
        .pot_write_addr(pot_write_addr), .pot_write_data(pot_write_data),
        .pot_write_we(pot_write_we), .spk_write_addr(spk_write_addr),
        .spk_write_data(spk_write_data), .spk_write_we(spk_write_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic signed [15:0] pot_mem [512];
    logic [7:0]         beta_mem [512];
    assign pot_read_data  = pot_mem[pot_read_addr];
    assign beta_read_data = beta_mem[beta_read_addr];

    typedef struct { int u; int beta; int cur; int pot; int spk; } vec_t;
    typedef struct { int cyc; int addr; int data; int spk; int spk_addr; int spk_we; } wr_t;

    vec_t vecs [12];
    int   cur_tab [N];
    int   exp_pot [N];
    int   exp_spk [N];
    wr_t  wr_q [$];
    int   acc_q [$];
    int   done_q [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pot_write_we || spk_write_we)
            wr_q.push_back('{cyc, int'(pot_write_addr), int'(pot_write_data), int'(spk_write_data),
                             int'(spk_write_addr), int'(spk_write_we)});
        if (done) done_q.push_back(cyc);
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic check_zero(input string nm);
        chk(nm, int'(|{ac_ready, busy, done, pot_write_we, spk_write_we, spk_write_data, pot_read_addr,
                       beta_read_addr, pot_write_addr, spk_write_addr, pot_write_data}), 0);
    endtask

    task automatic clear_all();
        for (int a = 0; a < 512; a++) begin
            pot_mem[a]  = '0;
            beta_mem[a] = '0;
        end
        for (int i = 0; i < N; i++) begin
            cur_tab[i] = 0;
            exp_pot[i] = 0;
            exp_spk[i] = 0;
        end
    endtask

    // currents i*40 with u=0: potential equals the current, fires once it reaches 1024
    task automatic load_ramp();
        clear_all();
        for (int i = 0; i < N; i++) begin
            cur_tab[i] = i * 40;
            exp_spk[i] = (i * 40 >= 1024) ? 1 : 0;
            exp_pot[i] = exp_spk[i] ? i * 40 - 1024 : i * 40;
        end
    endtask

    task automatic run_pass(input int b, input bit bubbles, input bit mid_start, input int stop_after);
        int i = 0;
        int k = 0;
        bit pulsed;
        wr_q.delete();
        acc_q.delete();
        done_q.delete();
        @(negedge clk);
        base_addr = 9'(b);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 9'h1ff;
        while (i < stop_after && k < 400) begin
            ac_valid = bubbles ? (k % 2 == 0) : 1'b1;
            ac_data  = 16'(cur_tab[i]);
            start    = mid_start && (i == 20) && ac_valid;
            #1;
            if (ac_valid && ac_ready) begin
                acc_q.push_back(cyc + 1);
                i++;
            end
            pulsed = start;
            @(negedge clk);
            start = 1'b0;
            k++;
            if (pulsed) begin
                #1 chk("busy_mid_start", int'(busy), 1);
            end
        end
        if (i < stop_after) chk("accept_timeout", i, stop_after);
        ac_valid = 1'b0;
    endtask

    task automatic finish_pass(input int b);
        int w = 0;
        while (done_q.size() == 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", done_q.size(), 1);
        chk("write_count", wr_q.size(), N);
        chk("busy_after_done", int'(busy), 0);
        for (int k = 0; k < wr_q.size() && k < N && k < acc_q.size(); k++) begin
            chk($sformatf("pot_addr[%0d]", k), wr_q[k].addr, (b + k) % 512);
            chk($sformatf("spk_addr[%0d]", k), wr_q[k].spk_addr, (b + k) % 512);
            chk($sformatf("spk_we[%0d]", k), wr_q[k].spk_we, 1);
            chk($sformatf("pot_data[%0d]", k), wr_q[k].data, exp_pot[k]);
            chk($sformatf("spk_data[%0d]", k), wr_q[k].spk, exp_spk[k]);
            chk($sformatf("latency[%0d]", k), wr_q[k].cyc, acc_q[k] + 2);
        end
        if (wr_q.size() > 0 && done_q.size() > 0)
            chk("done_timing", done_q[0], wr_q[wr_q.size()-1].cyc + 1);
    endtask

    initial begin
        vecs[0]  = '{0,     128, 100,    100,   0};
        vecs[1]  = '{0,     128, 1024,   0,     1};
        vecs[2]  = '{0,     128, 2000,   976,   1};
        vecs[3]  = '{0,     128, -50,    -50,   0};
        vecs[4]  = '{1000,  192, 0,      750,   0};
        vecs[5]  = '{1000,  192, 300,    26,    1};
`ifdef SATURATE_EN
        vecs[6]  = '{32767, 255, 32767,  31743, 1};
        vecs[8]  = '{-32768, 255, -32768, -32768, 0};
`else
        vecs[6]  = '{32767, 255, 32767,  -130,  0};
        vecs[8]  = '{-32768, 255, -32768, 128,  0};
`endif
        vecs[7]  = '{-1001, 128, 0,      -501,  0};
        vecs[9]  = '{0,     0,   1023,   1023,  0};
        vecs[10] = '{5000,  0,   0,      0,     0};
        vecs[11] = '{2048,  255, 0,      1016,  1};

        #2 reset = 1'b0;
        #1 check_zero("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // table pass: base 0, back-to-back accepts
        clear_all();
        for (int i = 0; i < 12; i++) begin
            pot_mem[i]  = 16'(vecs[i].u);
            beta_mem[i] = 8'(vecs[i].beta);
            cur_tab[i]  = vecs[i].cur;
            exp_pot[i]  = vecs[i].pot;
            exp_spk[i]  = vecs[i].spk;
        end
        run_pass(0, 1'b0, 1'b0, N);
        finish_pass(0);

        // bubbles every other cycle, ignored start mid-pass
        load_ramp();
        run_pass(448, 1'b1, 1'b1, N);
        finish_pass(448);

        // address wrap past 511
        load_ramp();
        run_pass(480, 1'b0, 1'b0, N);
        finish_pass(480);

        // reset after 10 accepts
        load_ramp();
        run_pass(200, 1'b0, 1'b0, 10);
        #2 reset = 1'b0;
        #1 check_zero("reset_mid_pass");
        @(negedge clk);
        reset = 1'b1;
        wr_q.delete();
        ac_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("ready_after_reset", int'(ac_ready), 0);
        chk("busy_after_reset", int'(busy), 0);
        chk("writes_after_reset", wr_q.size(), 0);
        ac_valid = 1'b0;

        run_pass(64, 1'b0, 1'b0, N);
        finish_pass(64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
